// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment display scanner.
// Display words arrive over a valid/ready handshake into a shadow buffer.
// The shadow moves into the display registers only at a frame wrap, so a frame never tears.
// Optional feature macro: SEG7_LZB_EN enables leading-zero blanking, computed when a word is swapped in.
module seg7_scan_ctrl #(
  parameter int unsigned DIGITS         = 8,
  parameter int unsigned DIV            = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_data,
  input  logic [DIGITS-1:0]     in_dp,
  input  logic [DIGITS-1:0]     in_blank,
  input  logic                  hold,
  output logic [7:0]            o_seg,
  output logic [DIGITS-1:0]     o_sel,
  output logic                  frame_tick
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DW    = 4 * DIGITS;
  localparam logic [7:0]        SEG_INV = {8{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] SEL_INV = {DIGITS{SEL_ACTIVE_LOW}};

  logic [PRE_W-1:0]  pre;
  logic [IDX_W-1:0]  idx;
  logic [DW-1:0]     sh_data;
  logic [DIGITS-1:0] sh_dp;
  logic [DIGITS-1:0] sh_blank;
  logic [DW-1:0]     disp_data;
  logic [DIGITS-1:0] disp_dp;
  logic [DIGITS-1:0] disp_mask;

  logic              adv_c;
  logic              wrap_c;
  logic [DIGITS-1:0] lzb_c;
  logic [3:0]        nib_c;
  logic [7:0]        seg_c;
  logic [DIGITS-1:0] sel_c;

  // Hex nibble to active-high gfedcba pattern.
  function automatic logic [6:0] dec(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Advance and wrap strobes; nothing moves while held.
  always_comb begin
    adv_c  = !hold && (pre == PRE_W'(DIV - 1));
    wrap_c = adv_c && (idx == IDX_W'(DIGITS - 1));
  end

  // Prescaler, digit index and frame pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre        <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap_c;
      if (!hold) begin
        if (adv_c) begin
          pre <= '0;
          idx <= wrap_c ? '0 : idx + IDX_W'(1);
        end else begin
          pre <= pre + PRE_W'(1);
        end
      end
    end
  end

`ifdef SEG7_LZB_EN
  logic lead;

  // Leading-zero mask of the word about to be displayed; digit 0 always stays lit.
  always_comb begin
    lzb_c = '0;
    lead  = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if ((sh_data[4*i +: 4] != 4'h0) || sh_dp[i]) lead = 1'b0;
      lzb_c[i] = lead;
    end
  end
`else
  // Zeros are always shown; only the explicit blank mask darkens digits.
  always_comb begin
    lzb_c = '0;
  end
`endif

  // Handshake into the shadow buffer and swap into the display registers at frame wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready  <= 1'b1;
      sh_data   <= '0;
      sh_dp     <= '0;
      sh_blank  <= '0;
      disp_data <= '0;
      disp_dp   <= '0;
      disp_mask <= '1;
    end else if (in_valid && in_ready) begin
      sh_data  <= in_data;
      sh_dp    <= in_dp;
      sh_blank <= in_blank;
      in_ready <= 1'b0;
    end else if (wrap_c && !in_ready) begin
      disp_data <= sh_data;
      disp_dp   <= sh_dp;
      disp_mask <= sh_blank | lzb_c;
      in_ready  <= 1'b1;
    end
  end

  // Segment and select patterns for the current digit, active-high.
  always_comb begin
    nib_c = disp_data[{idx, 2'b00} +: 4];
    seg_c = disp_mask[idx] ? 8'h00 : {disp_dp[idx], dec(nib_c)};
    sel_c = DIGITS'(1) << idx;
  end

  // Registered pin drivers, frozen while held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_seg <= SEG_INV;
      o_sel <= SEL_INV;
    end else if (!hold) begin
      o_seg <= seg_c ^ SEG_INV;
      o_sel <= sel_c ^ SEL_INV;
    end
  end

endmodule
